i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the maximum number of WAIT cycles before a transaction is aborted (range 2..65535).
REQ-002 Parameter GAP_CYCLES, default 8, SHALL set the number of idle cycles between transactions to guarantee bus-free time (range 1..255).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester transaction request, level, held until own rsp_valid.
REQ-006 req_addr  input  14  {addr1[6:0], addr0[6:0]} 7-bit slave addresses.
REQ-007 req_rw  input  2  per-requester direction, 1 = read, 0 = write.
REQ-008 req_wdata  input  16  {wdata1, wdata0} write bytes.
REQ-009 req_speed  input  2  per-requester speed, 0 = 100 kbps, 1 = 400 kbps.
REQ-010 gnt  output  2  one-hot grant, high from ISSUE through RESP inclusive.
REQ-011 rsp_valid  output  2  one-cycle completion pulse to the served requester.
REQ-012 rsp_rdata  output  8  read byte, valid with rsp_valid, held until next response.
REQ-013 rsp_err  output  2  status with rsp_valid: 00 ok, 01 NACK, 10 timeout.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 m_start  output  1  one-cycle pulse starting a byte transaction on the I2C master.
REQ-016 m_addr / m_rw / m_wdata / m_speed  output  7/1/8/1  latched command fields, stable from ISSUE until RESP exit.
REQ-017 m_abort  output  1  one-cycle pulse forcing the master back to idle on timeout.
REQ-018 m_done  input  1  one-cycle pulse from the master, transaction finished.
REQ-019 m_nack  input  1  valid with m_done, 1 = slave did not acknowledge.
REQ-020 m_rdata  input  8  valid with m_done, received byte.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, GAP, in that sequence only.
REQ-022 IDLE: when req != 0, the block SHALL select a winner, latch its addr/rw/wdata/speed, and enter ISSUE next cycle.
REQ-023 Arbitration SHALL be round-robin: a single request wins; when both request, the requester not equal to last_served wins.
REQ-024 last_served SHALL update to the winner in RESP; reset value is 1, so requester 0 wins the first tie.
REQ-025 ISSUE (1 cycle): m_start = 1, gnt[winner] = 1, timeout counter cleared; next state WAIT.
REQ-026 WAIT: the counter SHALL increment each cycle; m_done SHALL move to RESP with rdata = m_rdata when rw = 1, else 0x00, and err = {0, m_nack}.
REQ-027 WAIT: if the counter reaches TIMEOUT_CYCLES-1 without m_done, m_abort SHALL pulse in that cycle and the block SHALL enter RESP with err = 10 and rdata = 0x00.
REQ-028 m_done and timeout in the same cycle: m_done SHALL win, with no m_abort.
REQ-029 RESP (1 cycle): rsp_valid[winner] = 1 with rsp_rdata/rsp_err; next state GAP.
REQ-030 GAP SHALL last exactly GAP_CYCLES cycles with gnt = 0, then return to IDLE; requests are not sampled in GAP.
REQ-031 Latency: req sampled in IDLE cycle N -> m_start in N+1; m_done in cycle M -> rsp_valid in M+1.
REQ-032 Deassertion of req or changes to req fields after latching SHALL be ignored; the transaction always completes.
REQ-033 m_done outside WAIT SHALL be ignored.
REQ-034 A requester still holding req after its rsp_valid SHALL be re-arbitrated normally after GAP.

Reset
REQ-035 rst SHALL force IDLE, last_served = 1, counters = 0, gnt/rsp_valid/m_start/m_abort = 0, rsp_rdata = 0x00, rsp_err = 00, m_* fields = 0, busy = 0.
REQ-036 rst in any state, including mid-WAIT, SHALL discard the transaction with no rsp_valid and no m_abort pulse.

Verification
REQ-037 Single write: req = 01, addr0 = 0x50, rw0 = 0, wdata0 = 0xA5; m_done with m_nack = 0 after 20 cycles -> m_start one cycle after req, m_addr = 0x50, m_wdata = 0xA5, rsp_valid = 01, rsp_err = 00.
REQ-038 Tie after reset: req = 11 held -> requester 0 served first, then requester 1 after GAP_CYCLES, then requester 0 again (alternation).
REQ-039 Read with NACK: req = 10, rw1 = 1, m_done with m_nack = 1 and m_rdata = 0x3C -> rsp_valid = 10, rsp_err = 01, rsp_rdata = 0x3C.
REQ-040 Timeout: TIMEOUT_CYCLES = 16, no m_done -> m_abort pulses on the 16th WAIT cycle, next cycle rsp_err = 10 and rsp_rdata = 0x00.
REQ-041 m_done coincident with the final timeout cycle -> no m_abort, rsp_err = 00.
REQ-042 rst asserted mid-WAIT -> next cycle busy = 0, gnt = 00, and rsp_valid never pulses for that transaction.

Source files
------------

// File: rtl/i2c_arbiter_if.sv
// Bundle of requester-side and I2C-master-side signals for i2c_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of
// the requesters and the byte-level I2C master engine.
interface i2c_arbiter_if;
  // requester side
  logic [1:0]  req;
  logic [13:0] req_addr;
  logic [1:0]  req_rw;
  logic [15:0] req_wdata;
  logic [1:0]  req_speed;
  logic [1:0]  gnt;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy;
  // I2C master engine side
  logic        m_start;
  logic [6:0]  m_addr;
  logic        m_rw;
  logic [7:0]  m_wdata;
  logic        m_speed;
  logic        m_abort;
  logic        m_done;
  logic        m_nack;
  logic [7:0]  m_rdata;

  modport master (
    input  req, req_addr, req_rw, req_wdata, req_speed,
    input  m_done, m_nack, m_rdata,
    output gnt, rsp_valid, rsp_rdata, rsp_err, busy,
    output m_start, m_addr, m_rw, m_wdata, m_speed, m_abort
  );

  modport slave (
    output req, req_addr, req_rw, req_wdata, req_speed,
    output m_done, m_nack, m_rdata,
    input  gnt, rsp_valid, rsp_rdata, rsp_err, busy,
    input  m_start, m_addr, m_rw, m_wdata, m_speed, m_abort
  );
endinterface

// File: rtl/i2c_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-level I2C master.
// It serves one transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> GAP.
// A timeout in WAIT aborts the transaction. A fixed GAP guarantees bus-free
// time before the next arbitration.
module i2c_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 8
) (
  input logic          clk,
  input logic          rst,
  i2c_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic        last_served;
  logic        winner;
  logic        pick;
  logic [15:0] tmo_cnt;
  logic [7:0]  gap_cnt;
  logic        tmo_hit;

  // Round-robin choice: a lone request wins, and a tie goes to whoever was not served last.
  always_comb begin
    pick = 1'b0;
    case (bus.req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_served;
      default: pick = 1'b0;
    endcase
  end

  // The abort must appear in the final WAIT cycle itself and must yield to a same-cycle m_done, so it cannot be registered.
  assign tmo_hit     = (state == WAIT) && (tmo_cnt == TMO_LAST) && !bus.m_done;
  assign bus.m_abort = tmo_hit && !rst;

  // Transaction sequencer with registered grant, response and command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_served   <= 1'b1;
      winner        <= 1'b0;
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
      bus.gnt       <= 2'b00;
      bus.rsp_valid <= 2'b00;
      bus.rsp_rdata <= 8'h00;
      bus.rsp_err   <= 2'b00;
      bus.busy      <= 1'b0;
      bus.m_start   <= 1'b0;
      bus.m_addr    <= 7'h00;
      bus.m_rw      <= 1'b0;
      bus.m_wdata   <= 8'h00;
      bus.m_speed   <= 1'b0;
    end else begin
      bus.m_start   <= 1'b0;
      bus.rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            winner      <= pick;
            bus.m_addr  <= pick ? bus.req_addr[13:7]  : bus.req_addr[6:0];
            bus.m_rw    <= pick ? bus.req_rw[1]       : bus.req_rw[0];
            bus.m_wdata <= pick ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
            bus.m_speed <= pick ? bus.req_speed[1]    : bus.req_speed[0];
            bus.gnt     <= pick ? 2'b10 : 2'b01;
            bus.m_start <= 1'b1;
            bus.busy    <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (bus.m_done) begin
            bus.rsp_rdata <= bus.m_rw ? bus.m_rdata : 8'h00;
            bus.rsp_err   <= {1'b0, bus.m_nack};
            bus.rsp_valid <= winner ? 2'b10 : 2'b01;
            state         <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.rsp_rdata <= 8'h00;
            bus.rsp_err   <= 2'b10;
            bus.rsp_valid <= winner ? 2'b10 : 2'b01;
            state         <= RESP;
          end
        end
        RESP: begin
          last_served <= winner;
          bus.gnt     <= 2'b00;
          gap_cnt     <= '0;
          state       <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.gnt  <= 2'b00;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter.
// It uses a 16-cycle timeout and a 4-cycle gap.
module tb_i2c_arbiter;

  localparam int TMO = 16;
  localparam int GAPC = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  i2c_arbiter_if bus ();

  i2c_arbiter #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [6:0] a0, input logic [6:0] a1,
                               input logic [1:0] rw, input logic [7:0] wd0, input logic [7:0] wd1,
                               input logic [1:0] spd);
    bus.req       = req;
    bus.req_addr  = {a1, a0};
    bus.req_rw    = rw;
    bus.req_wdata = {wd1, wd0};
    bus.req_speed = spd;
  endtask

  // Runs one full transaction starting in an IDLE cycle with req already driven.
  // done_cycle is the 1-based WAIT cycle carrying m_done; 0 means never (timeout).
  task automatic serveOne(input string tag, input logic [1:0] exp_gnt, input logic [6:0] exp_addr,
                          input logic [7:0] exp_wdata, input logic exp_rw, input logic exp_speed,
                          input int done_cycle, input logic nack, input logic [7:0] rd,
                          input logic [7:0] exp_rdata, input logic [1:0] exp_err,
                          input logic [1:0] req_after, input bit drop_early);
    logic [13:0] sv_addr;
    logic [15:0] sv_wdata;
    logic [1:0]  sv_rw;
    bit          end_now;
    checkOutput({tag, " idle_busy"}, bus.busy, 1'b0);
    checkOutput({tag, " idle_start"}, bus.m_start, 1'b0);
    tick();
    checkOutput({tag, " issue_start"}, bus.m_start, 1'b1);
    checkOutput({tag, " issue_gnt"}, bus.gnt, exp_gnt);
    checkOutput({tag, " issue_addr"}, bus.m_addr, exp_addr);
    checkOutput({tag, " issue_wdata"}, bus.m_wdata, exp_wdata);
    checkOutput({tag, " issue_rw"}, bus.m_rw, exp_rw);
    checkOutput({tag, " issue_speed"}, bus.m_speed, exp_speed);
    checkOutput({tag, " issue_busy"}, bus.busy, 1'b1);
    sv_addr  = bus.req_addr;
    sv_wdata = bus.req_wdata;
    sv_rw    = bus.req_rw;
    bus.req_addr  = ~sv_addr;
    bus.req_wdata = ~sv_wdata;
    bus.req_rw    = ~sv_rw;
    if (drop_early) bus.req = 2'b00;
    tick();
    checkOutput({tag, " wait_start"}, bus.m_start, 1'b0);
    checkOutput({tag, " wait_gnt"}, bus.gnt, exp_gnt);
    for (int c = 1; c <= TMO; c++) begin
      if (c == done_cycle) begin
        bus.m_done  = 1'b1;
        bus.m_nack  = nack;
        bus.m_rdata = rd;
      end
      #1;
      checkOutput($sformatf("%s abort_c%0d", tag, c), bus.m_abort, (c == TMO) && (c != done_cycle));
      end_now = (c == done_cycle) || (c == TMO);
      tick();
      bus.m_done  = 1'b0;
      bus.m_nack  = 1'b0;
      bus.m_rdata = 8'h00;
      if (end_now) break;
    end
    checkOutput({tag, " resp_valid"}, bus.rsp_valid, exp_gnt);
    checkOutput({tag, " resp_err"}, bus.rsp_err, exp_err);
    checkOutput({tag, " resp_rdata"}, bus.rsp_rdata, exp_rdata);
    checkOutput({tag, " resp_gnt"}, bus.gnt, exp_gnt);
    checkOutput({tag, " resp_abort"}, bus.m_abort, 1'b0);
    checkOutput({tag, " resp_addr"}, bus.m_addr, exp_addr);
    bus.req_addr  = sv_addr;
    bus.req_wdata = sv_wdata;
    bus.req_rw    = sv_rw;
    bus.req       = req_after;
    tick();
    checkOutput({tag, " gap_valid"}, bus.rsp_valid, 2'b00);
    checkOutput({tag, " gap_gnt"}, bus.gnt, 2'b00);
    checkOutput({tag, " gap_busy"}, bus.busy, 1'b1);
    checkOutput({tag, " gap_rdata_held"}, bus.rsp_rdata, exp_rdata);
    bus.m_done  = 1'b1;
    bus.m_rdata = 8'hEE;
    tick();
    bus.m_done  = 1'b0;
    bus.m_rdata = 8'h00;
    checkOutput({tag, " gap_done_ignored"}, bus.rsp_valid, 2'b00);
    repeat (GAPC - 2) tick();
    checkOutput({tag, " gap_last_busy"}, bus.busy, 1'b1);
    tick();
    checkOutput({tag, " back_idle_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    int pulses;
    int aborts;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    applyStimulus(2'b00, 7'h00, 7'h00, 2'b00, 8'h00, 8'h00, 2'b00);
    bus.m_done  = 1'b0;
    bus.m_nack  = 1'b0;
    bus.m_rdata = 8'h00;
    repeat (3) tick();
    checkOutput("rst busy", bus.busy, 1'b0);
    checkOutput("rst gnt", bus.gnt, 2'b00);
    checkOutput("rst rsp_valid", bus.rsp_valid, 2'b00);
    checkOutput("rst m_start", bus.m_start, 1'b0);
    checkOutput("rst m_abort", bus.m_abort, 1'b0);
    checkOutput("rst rsp_rdata", bus.rsp_rdata, 8'h00);
    checkOutput("rst rsp_err", bus.rsp_err, 2'b00);
    checkOutput("rst m_addr", bus.m_addr, 7'h00);
    checkOutput("rst m_wdata", bus.m_wdata, 8'h00);
    checkOutput("rst m_rw", bus.m_rw, 1'b0);
    checkOutput("rst m_speed", bus.m_speed, 1'b0);
    rst = 1'b0;
    tick();

    $display("[TB] single write from requester 0");
    applyStimulus(2'b01, 7'h50, 7'h00, 2'b00, 8'hA5, 8'h00, 2'b00);
    serveOne("wr0", 2'b01, 7'h50, 8'hA5, 1'b0, 1'b0, 10, 1'b0, 8'hFF, 8'h00, 2'b00, 2'b00, 1'b0);

    $display("[TB] read with NACK from requester 1, req dropped early");
    applyStimulus(2'b10, 7'h00, 7'h3A, 2'b10, 8'h00, 8'h77, 2'b10);
    serveOne("rdnack", 2'b10, 7'h3A, 8'h77, 1'b1, 1'b1, 5, 1'b1, 8'h3C, 8'h3C, 2'b01, 2'b00, 1'b1);

    $display("[TB] timeout on requester 1 read");
    applyStimulus(2'b10, 7'h00, 7'h15, 2'b10, 8'h00, 8'h00, 2'b00);
    serveOne("tmo", 2'b10, 7'h15, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h99, 8'h00, 2'b10, 2'b00, 1'b0);

    $display("[TB] m_done coincident with final timeout cycle");
    applyStimulus(2'b01, 7'h2B, 7'h00, 2'b01, 8'h5A, 8'h00, 2'b01);
    serveOne("coin", 2'b01, 7'h2B, 8'h5A, 1'b1, 1'b1, TMO, 1'b0, 8'hC3, 8'hC3, 2'b00, 2'b00, 1'b0);

    $display("[TB] reset in the final WAIT cycle");
    applyStimulus(2'b01, 7'h10, 7'h00, 2'b00, 8'h01, 8'h00, 2'b00);
    tick();
    checkOutput("rstwait issue_start", bus.m_start, 1'b1);
    tick();
    repeat (TMO - 1) tick();
    rst = 1'b1;
    #1;
    checkOutput("rstwait abort_gated", bus.m_abort, 1'b0);
    tick();
    checkOutput("rstwait busy", bus.busy, 1'b0);
    checkOutput("rstwait gnt", bus.gnt, 2'b00);
    checkOutput("rstwait rsp_valid", bus.rsp_valid, 2'b00);
    checkOutput("rstwait m_addr", bus.m_addr, 7'h00);
    rst = 1'b0;
    bus.req = 2'b00;
    pulses = 0;
    aborts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid != 2'b00) pulses++;
      if (bus.m_abort) aborts++;
    end
    checkOutput("rstwait no_rsp", pulses, 0);
    checkOutput("rstwait no_abort", aborts, 0);

    $display("[TB] tie held: alternation starting with requester 0");
    applyStimulus(2'b11, 7'h21, 7'h42, 2'b00, 8'h11, 8'h22, 2'b00);
    serveOne("tie0", 2'b01, 7'h21, 8'h11, 1'b0, 1'b0, 3, 1'b0, 8'h00, 8'h00, 2'b00, 2'b11, 1'b0);
    serveOne("tie1", 2'b10, 7'h42, 8'h22, 1'b0, 1'b0, 3, 1'b0, 8'h00, 8'h00, 2'b00, 2'b11, 1'b0);
    serveOne("tie2", 2'b01, 7'h21, 8'h11, 1'b0, 1'b0, 3, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0);

    tick();
    checkOutput("final idle busy", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
